// File: rtl/dcache_port_driver_pkg.sv
// rtl/dcache_port_driver_pkg.sv - D$ port types, widths and command record for the port driver
package dcache_port_driver_pkg;

    localparam int XLEN               = 64;
    localparam int DCACHE_INDEX_WIDTH = 12;
    localparam int DCACHE_TAG_WIDTH   = 44;
    localparam int ADDR_WIDTH         = DCACHE_INDEX_WIDTH + DCACHE_TAG_WIDTH;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [XLEN-1:0]               data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [XLEN/8-1:0]             data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic            data_gnt;
        logic            data_rvalid;
        logic [XLEN-1:0] data_rdata;
    } dcache_req_o_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [XLEN-1:0]       wdata;
        logic [XLEN/8-1:0]     be;
        logic [1:0]            size;
    } dcache_drv_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_TAG,
        ST_WAIT_RD
    } drv_state_e;

    function automatic logic [DCACHE_INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[DCACHE_INDEX_WIDTH-1:0];
    endfunction

    function automatic logic [DCACHE_TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1:DCACHE_INDEX_WIDTH];
    endfunction

endpackage

// File: rtl/dcache_port_driver_fifo.sv
// rtl/dcache_port_driver_fifo.sv - command FIFO with synchronous flush and registered full/empty
module dcache_port_driver_fifo #(
    parameter int  Depth = 4,
    parameter type dtype = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    output logic full,
    output logic empty,
    input  dtype wdata,
    input  logic push,
    output dtype rdata,
    input  logic pop
);

    localparam int PtrW = $clog2(Depth);
    localparam logic [PtrW:0] CntFull = (PtrW+1)'(Depth);

    dtype            mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW:0]   cnt_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (cnt_q == CntFull);
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            cnt_q <= cnt_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read once the count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/dcache_port_driver.sv
// rtl/dcache_port_driver.sv - sequencer turning load/store commands into the two-phase D$ port protocol
module dcache_port_driver
    import dcache_port_driver_pkg::*;
#(
    parameter int CmdDepth   = 4,
    parameter int TimeoutCyc = 1024,
    parameter int CntWidth   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [XLEN-1:0]       cmd_wdata_i,
    input  logic [XLEN/8-1:0]     cmd_be_i,
    input  logic [1:0]            cmd_size_i,
    output logic                  rsp_valid_o,
    output logic [XLEN-1:0]       rsp_rdata_o,
    output dcache_req_i_t         req_port_o,
    input  dcache_req_o_t         req_port_i,
    output logic                  busy_o,
    output logic [CntWidth-1:0]   load_cnt_o,
    output logic [CntWidth-1:0]   store_cnt_o,
    output logic                  timeout_o
);

    localparam logic [15:0] WdLimit = (TimeoutCyc > 65536) ? 16'hFFFF : 16'(TimeoutCyc - 1);

    drv_state_e      state_q, state_d;
    dcache_drv_cmd_t cmd_q;
    dcache_drv_cmd_t cmd_in;
    dcache_drv_cmd_t fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            load_done;
    logic            store_done;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_rdata_q;
    logic [CntWidth-1:0] load_cnt_q;
    logic [CntWidth-1:0] store_cnt_q;
    logic [15:0]     wd_q, wd_d;
    logic            wd_hit;
    logic            timeout_q;

    assign cmd_in = '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i, be: cmd_be_i, size: cmd_size_i};

    dcache_port_driver_fifo #(
        .Depth (CmdDepth),
        .dtype (dcache_drv_cmd_t)
    ) u_cmd_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .flush (flush_i),
        .full  (fifo_full),
        .empty (fifo_empty),
        .wdata (cmd_in),
        .push  (cmd_valid_i && cmd_ready_o),
        .rdata (fifo_head),
        .pop   (pop)
    );

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        load_done  = 1'b0;
        store_done = 1'b0;
        req_port_o = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !flush_i) begin
                    pop     = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                req_port_o.data_req      = 1'b1;
                req_port_o.address_index = addr_index(cmd_q.addr);
                req_port_o.data_we       = cmd_q.we;
                req_port_o.data_be       = cmd_q.be;
                req_port_o.data_size     = cmd_q.size;
                req_port_o.data_wdata    = cmd_q.wdata;
                // Stores present the tag with the index; loads send it in the following phase.
                if (cmd_q.we) begin
                    req_port_o.address_tag = addr_tag(cmd_q.addr);
                end
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (req_port_i.data_gnt) begin
                    if (cmd_q.we) begin
                        store_done = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_TAG;
                    end
                end
            end
            ST_TAG: begin
                req_port_o.tag_valid   = 1'b1;
                req_port_o.address_tag = addr_tag(cmd_q.addr);
                if (flush_i) begin
                    req_port_o.kill_req = 1'b1;
                    state_d             = ST_IDLE;
                end else if (req_port_i.data_rvalid) begin
                    load_done = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (flush_i) begin
                    req_port_o.kill_req = 1'b1;
                    state_d             = ST_IDLE;
                end else if (req_port_i.data_rvalid) begin
                    load_done = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Watchdog counts cycles spent in one wait state; hit is flagged during the TimeoutCyc-th cycle.
    always_comb begin
        wd_d   = wd_q;
        wd_hit = 1'b0;
        if (state_q == ST_IDLE || state_d != state_q) begin
            wd_d = '0;
        end else begin
            wd_hit = (wd_q >= WdLimit);
            if (wd_q != 16'hFFFF) begin
                wd_d = wd_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            wd_q        <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= load_done;
            wd_q        <= wd_d;
            if (pop) begin
                cmd_q <= fifo_head;
            end
            if (load_done) begin
                rsp_rdata_q <= req_port_i.data_rdata;
                load_cnt_q  <= load_cnt_q + CntWidth'(1);
            end
            if (store_done) begin
                store_cnt_q <= store_cnt_q + CntWidth'(1);
            end
            if (wd_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign cmd_ready_o = !fifo_full;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;
    assign load_cnt_o  = load_cnt_q;
    assign store_cnt_o = store_cnt_q;
    assign timeout_o   = timeout_q || wd_hit;

endmodule

// File: tb/tb_dcache_port_driver.sv
// tb/tb_dcache_port_driver.sv - bench for dcache_port_driver with a byte-addressed cache port model
module tb_dcache_port_driver;
    import dcache_port_driver_pkg::*;

    localparam int Depth = 4;
    localparam int Tmo   = 64;
    localparam int CW    = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  flush = 1'b0;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_ready;
    logic                  cmd_we = 1'b0;
    logic [ADDR_WIDTH-1:0] cmd_addr = '0;
    logic [XLEN-1:0]       cmd_wdata = '0;
    logic [XLEN/8-1:0]     cmd_be = '0;
    logic [1:0]            cmd_size = '0;
    logic                  rsp_valid;
    logic [XLEN-1:0]       rsp_rdata;
    dcache_req_i_t         req_o;
    dcache_req_o_t         req_i = '0;
    logic                  busy;
    logic [CW-1:0]         load_cnt;
    logic [CW-1:0]         store_cnt;
    logic                  timeout;

    int checks = 0;
    int errors = 0;
    int exp_ld = 0;
    int exp_st = 0;
    int kill_cnt = 0;
    logic [63:0] exp_q[$];

    logic [7:0]  mem [logic [55:0]];
    bit          gnt_en = 1'b1;
    bit          rd_hold = 1'b0;
    bit          rd_pend = 1'b0;
    logic [11:0] ld_idx = '0;
    logic [55:0] rd_addr = '0;

    always #5 clk = ~clk;

    dcache_port_driver #(
        .CmdDepth   (Depth),
        .TimeoutCyc (Tmo),
        .CntWidth   (CW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .cmd_be_i    (cmd_be),
        .cmd_size_i  (cmd_size),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .req_port_o  (req_o),
        .req_port_i  (req_i),
        .busy_o      (busy),
        .load_cnt_o  (load_cnt),
        .store_cnt_o (store_cnt),
        .timeout_o   (timeout)
    );

    function automatic logic [7:0] mem_rd8(input logic [55:0] a);
        return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'h5A);
    endfunction

    function automatic logic [63:0] def_dword(input logic [55:0] a);
        logic [63:0] d;
        logic [55:0] b;
        for (int i = 0; i < 8; i++) begin
            b = a + 56'(i);
            d[8*i +: 8] = b[7:0] ^ 8'h5A;
        end
        return d;
    endfunction

    // Cache port model: answers at posedge+2, after test stimulus settles at posedge+1.
    initial begin : port_model
        logic [55:0] wa;
        logic [63:0] rd;
        forever begin
            @(posedge clk);
            #2;
            req_i.data_gnt    = 1'b0;
            req_i.data_rvalid = 1'b0;
            if (!rst_n) begin
                rd_pend = 1'b0;
                continue;
            end
            if (req_o.kill_req) begin
                rd_pend = 1'b0;
            end else if (req_o.tag_valid) begin
                rd_addr = {req_o.address_tag, ld_idx};
                rd_pend = 1'b1;
            end
            if (rd_pend && !rd_hold) begin
                for (int i = 0; i < 8; i++) rd[8*i +: 8] = mem_rd8(rd_addr + 56'(i));
                req_i.data_rvalid = 1'b1;
                req_i.data_rdata  = rd;
                rd_pend = 1'b0;
            end
            if (req_o.data_req && gnt_en) begin
                req_i.data_gnt = 1'b1;
                if (req_o.data_we) begin
                    wa = {req_o.address_tag, req_o.address_index};
                    for (int i = 0; i < 8; i++)
                        if (req_o.data_be[i]) mem[wa + 56'(i)] = req_o.data_wdata[8*i +: 8];
                end else begin
                    ld_idx = req_o.address_index;
                end
            end
        end
    end

    initial begin : rsp_monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (req_o.kill_req) kill_cnt++;
            if (rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected got=%h exp=none", rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_rdata !== e) begin
                        errors++;
                        $display("FAIL rsp_data got=%h exp=%h", rsp_rdata, e);
                    end
                end
            end
        end
    end

    task automatic push_cmd(input logic we, input logic [55:0] addr, input logic [63:0] wdata,
                            input logic [7:0] be, input logic [1:0] size);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_be    = be;
        cmd_size  = size;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_wait got=ready0 exp=ready1");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s_drain got=pending%0d busy%b exp=pending0 busy0", name, exp_q.size(), busy);
        end
    endtask

    task automatic wait_tag(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_o.tag_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_o.tag_valid) begin
            errors++;
            $display("FAIL %s_tag_phase got=0 exp=1", name);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp got=%b exp=0", rsp_valid); end
        checks++; if (req_o !== '0) begin errors++; $display("FAIL reset_req got=%h exp=0", req_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (load_cnt !== '0 || store_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", load_cnt, store_cnt); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load;
        push_cmd(1'b1, 56'h8000_0040, 64'hDEAD_BEEF_0123_4567, 8'hFF, 2'd3);
        exp_st++;
        exp_q.push_back(64'hDEAD_BEEF_0123_4567);
        push_cmd(1'b0, 56'h8000_0040, 64'h0, 8'hFF, 2'd3);
        exp_ld++;
        drain("store_load");
        checks++; if (store_cnt !== CW'(exp_st)) begin errors++; $display("FAIL sl_store_cnt got=%0d exp=%0d", store_cnt, exp_st); end
        checks++; if (load_cnt !== CW'(exp_ld)) begin errors++; $display("FAIL sl_load_cnt got=%0d exp=%0d", load_cnt, exp_ld); end
    endtask

    task automatic test_back_to_back;
        logic [55:0] a;
        gnt_en = 1'b0;
        // One command sits in the FSM, so Depth+1 pushes are needed to fill the FIFO.
        for (int i = 0; i <= Depth; i++) begin
            a = 56'h8000_1000 + 56'(i * 8);
            exp_q.push_back(def_dword(a));
            push_cmd(1'b0, a, 64'h0, 8'hFF, 2'd3);
            exp_ld++;
        end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got=%b exp=0", cmd_ready); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_stall got=ready%b busy%b exp=ready0 busy1", cmd_ready, busy); end
        gnt_en = 1'b1;
        drain("b2b");
        checks++; if (load_cnt !== CW'(exp_ld)) begin errors++; $display("FAIL b2b_load_cnt got=%0d exp=%0d", load_cnt, exp_ld); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_byte_stores;
        for (int i = 0; i < 8; i++) begin
            push_cmd(1'b1, 56'h8000_0100 + 56'(i), 64'((i + 1) * 17), 8'h01, 2'd0);
            exp_st++;
        end
        exp_q.push_back(64'h8877_6655_4433_2211);
        push_cmd(1'b0, 56'h8000_0100, 64'h0, 8'hFF, 2'd3);
        exp_ld++;
        drain("bytes");
        checks++; if (store_cnt !== CW'(exp_st)) begin errors++; $display("FAIL bytes_store_cnt got=%0d exp=%0d", store_cnt, exp_st); end
    endtask

    task automatic test_flush;
        rd_hold = 1'b1;
        push_cmd(1'b0, 56'h8000_2000, 64'h0, 8'hFF, 2'd3);
        wait_tag("flush");
        repeat (3) @(posedge clk);
        #1;
        kill_cnt = 0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
        rd_hold = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (kill_cnt !== 1) begin errors++; $display("FAIL flush_kill_pulses got=%0d exp=1", kill_cnt); end
        checks++; if (load_cnt !== CW'(exp_ld)) begin errors++; $display("FAIL flush_load_cnt got=%0d exp=%0d", load_cnt, exp_ld); end
    endtask

    task automatic test_timeout;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_early got=%b exp=0", timeout); end
        rd_hold = 1'b1;
        exp_q.push_back(def_dword(56'h8000_3000));
        push_cmd(1'b0, 56'h8000_3000, 64'h0, 8'hFF, 2'd3);
        exp_ld++;
        wait_tag("tmo");
        for (int n = 1; n <= Tmo; n++) begin
            @(negedge clk);
            if (n == Tmo - 1) begin
                checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_cycle63 got=%b exp=0", timeout); end
            end
            if (n == Tmo) begin
                checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_cycle64 got=%b exp=1", timeout); end
            end
        end
        @(posedge clk);
        #1;
        rd_hold = 1'b0;
        drain("tmo");
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky got=%b exp=1", timeout); end
        checks++; if (load_cnt !== CW'(exp_ld)) begin errors++; $display("FAIL tmo_load_cnt got=%0d exp=%0d", load_cnt, exp_ld); end
    endtask

    task automatic test_reset_mid;
        rd_hold = 1'b1;
        push_cmd(1'b0, 56'h8000_4000, 64'h0, 8'hFF, 2'd3);
        wait_tag("rst");
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (req_o !== '0) begin errors++; $display("FAIL rst_req got=%h exp=0", req_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (load_cnt !== '0 || store_cnt !== '0) begin errors++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", load_cnt, store_cnt); end
        checks++; if (timeout !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_flags got=tmo%b ready%b exp=tmo0 ready1", timeout, cmd_ready); end
        @(posedge clk);
        #3;
        rd_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(def_dword(56'h8000_5008));
        push_cmd(1'b0, 56'h8000_5008, 64'h0, 8'hFF, 2'd3);
        drain("rst_after");
        checks++; if (load_cnt !== CW'(1)) begin errors++; $display("FAIL rst_after_cnt got=%0d exp=1", load_cnt); end
    endtask

    initial begin : main
        #1;
        test_reset;
        test_store_load;
        test_back_to_back;
        test_byte_stores;
        test_flush;
        test_timeout;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : global_limit
        #200000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule
